// File: rtl/ula_seq_cascata.sv
`default_nettype none
// ============================================================================
//  Module      : ula_seq_cascata
//  Description : Sequential driver for a shared 4-bit carry-lookahead ULA.
//                Latches wide operands, feeds them to the ULA one nibble per
//                cycle (LSB first), chains the ULA carry back into the next
//                nibble, assembles the wide result and accumulates the group
//                propagate/generate flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module ula_seq_cascata #(
    parameter int NIBBLES = 4                 // 4-bit slices per operation, 2..16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   A,
    input  logic [4*NIBBLES-1:0]   B,
    input  logic [2:0]             seletor,
    input  logic                   carry_in,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   resultado,
    output logic                   carry_out,
    output logic                   propagado,
    output logic                   gerado,
    output logic [3:0]             ula_A,
    output logic [3:0]             ula_B,
    output logic [2:0]             ula_seletor,
    output logic                   ula_carry_in,
    input  logic [3:0]             ula_resultado,
    input  logic                   ula_carry_out,
    input  logic                   ula_propagado,
    input  logic                   ula_gerado
);

    localparam int W   = 4 * NIBBLES;
    localparam int K_W = $clog2(NIBBLES);

    // Controller states
    localparam logic [0:0] c_ocioso = 1'b0;
    localparam logic [0:0] c_exec   = 1'b1;

    // Only the add operation uses the carry chain and the group flags
    localparam logic [2:0]     c_sel_soma = 3'b100;
    localparam logic [K_W-1:0] c_k_ultimo = K_W'(NIBBLES - 1);

    // ------------------------------------------------------------------------
    // State and operand registers
    // ------------------------------------------------------------------------
    logic [0:0]     r_estado;
    logic [K_W-1:0] r_k;
    logic           r_done;
    logic [W-1:0]   r_a_lat;
    logic [W-1:0]   r_b_lat;
    logic [2:0]     r_sel_lat;
    logic           r_cin_lat;
    logic           r_carry_ant;     // ULA carry out captured at the previous nibble
    logic           r_carry_out;
    logic           r_prop;
    logic           r_ger;
    logic [3:0]     r_nib [NIBBLES];

    logic           w_exec;
    logic           w_aceita;
    logic           w_soma;
    logic           w_ultimo;
    logic [3:0]     w_a_nib [NIBBLES];
    logic [3:0]     w_b_nib [NIBBLES];

    assign w_exec   = (r_estado == c_exec);
    // A start is only honoured while idle, which includes the done cycle
    assign w_aceita = (r_estado == c_ocioso) && start;
    assign w_soma   = (r_sel_lat == c_sel_soma);
    assign w_ultimo = (r_k == c_k_ultimo);

    // ------------------------------------------------------------------------
    // Nibble views of the latched operands
    // ------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NIBBLES; i++) begin : g_fatia
            assign w_a_nib[i] = r_a_lat[4*i +: 4];
            assign w_b_nib[i] = r_b_lat[4*i +: 4];
        end
    endgenerate

    // Sequencer: idle until a start, then walk k over every nibble once
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_estado <= c_ocioso;
            r_k      <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_estado)
                c_ocioso: begin
                    if (start) begin
                        r_estado <= c_exec;
                        r_k      <= '0;
                    end
                end
                c_exec: begin
                    if (w_ultimo) begin
                        r_estado <= c_ocioso;
                        r_k      <= '0;
                        r_done   <= 1'b1;
                    end else begin
                        r_k <= r_k + K_W'(1);
                    end
                end
                default: begin
                    r_estado <= c_ocioso;
                    r_k      <= '0;
                end
            endcase
        end
    end

    // Operand capture on an accepted start; starts while busy leave these alone
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_lat   <= '0;
            r_b_lat   <= '0;
            r_sel_lat <= 3'b000;
            r_cin_lat <= 1'b0;
        end else if (w_aceita) begin
            r_a_lat   <= A;
            r_b_lat   <= B;
            r_sel_lat <= seletor;
            r_cin_lat <= carry_in;
        end
    end

    // Carry chain register: ULA carry of nibble k feeds nibble k+1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_carry_ant <= 1'b0;
        end else if (w_aceita) begin
            r_carry_ant <= 1'b0;
        end else if (w_exec) begin
            r_carry_ant <= ula_carry_out;
        end
    end

    // Group flag accumulation and final carry, add operation only
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_carry_out <= 1'b0;
            r_prop      <= 1'b0;
            r_ger       <= 1'b0;
        end else if (w_aceita) begin
            r_carry_out <= 1'b0;
            r_prop      <= 1'b0;
            r_ger       <= 1'b0;
        end else if (w_exec && w_soma) begin
            // Propagate is a running AND; nibble 0 seeds it
            r_prop <= (r_k == '0) ? ula_propagado : (r_prop & ula_propagado);
            // Generate ripples LSB to MSB through the nibble propagates
            r_ger  <= ula_gerado | (ula_propagado & r_ger);
            if (w_ultimo) begin
                r_carry_out <= ula_carry_out;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Result nibbles: each slice clears on start and captures on its own k
    // ------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NIBBLES; i++) begin : g_resultado
            // Capture the ULA result while the sequencer points at this slice
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_nib[i] <= 4'h0;
                end else if (w_aceita) begin
                    r_nib[i] <= 4'h0;
                end else if (w_exec && (r_k == K_W'(i))) begin
                    r_nib[i] <= ula_resultado;
                end
            end
            assign resultado[4*i +: 4] = r_nib[i];
        end
    endgenerate

    // ULA drive: current nibble and chained carry while executing, zero otherwise
    always_comb begin
        ula_A        = 4'h0;
        ula_B        = 4'h0;
        ula_carry_in = 1'b0;
        if (w_exec) begin
            ula_A        = w_a_nib[r_k];
            ula_B        = w_b_nib[r_k];
            ula_carry_in = w_soma & ((r_k == '0) ? r_cin_lat : r_carry_ant);
        end
    end

    assign ula_seletor = r_sel_lat;
    assign busy        = w_exec;
    assign done        = r_done;
    assign carry_out   = r_carry_out;
    assign propagado   = r_prop;
    assign gerado      = r_ger;

endmodule
`default_nettype wire

// File: tb/tb_ula_seq_cascata.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ula_seq_cascata
//  Description : Self-checking bench for ula_seq_cascata with a behavioural
//                4-bit ULA attached and a scoreboard of wide-level results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ula_seq_cascata;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    typedef struct packed {
        logic [W-1:0] res;
        logic         co;
        logic         p;
        logic         g;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A, B;
    logic [2:0]   seletor;
    logic         carry_in;
    logic         busy, done, carry_out, propagado, gerado;
    logic [W-1:0] resultado;
    logic [3:0]   ula_A, ula_B, ula_resultado;
    logic [2:0]   ula_seletor;
    logic         ula_carry_in, ula_carry_out, ula_propagado, ula_gerado;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_on  = 1'b0;

    // Model state
    int     m_cnt  = 0;
    bit     m_done = 1'b0;
    logic [W-1:0] m_a = '0, m_b = '0;
    logic [2:0]   m_sel = 3'b000;
    logic         m_cin = 1'b0;
    exp_t   fila[$];

    always #5 clk = ~clk;

    ula_seq_cascata #(.NIBBLES(NIB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
        .seletor(seletor), .carry_in(carry_in), .busy(busy), .done(done),
        .resultado(resultado), .carry_out(carry_out), .propagado(propagado),
        .gerado(gerado), .ula_A(ula_A), .ula_B(ula_B), .ula_seletor(ula_seletor),
        .ula_carry_in(ula_carry_in), .ula_resultado(ula_resultado),
        .ula_carry_out(ula_carry_out), .ula_propagado(ula_propagado),
        .ula_gerado(ula_gerado)
    );

    // Behavioural 4-bit ULA; flags are driven for every op on purpose
    logic [4:0] w_s, w_s0;
    assign w_s  = {1'b0, ula_A} + {1'b0, ula_B} + {4'h0, ula_carry_in};
    assign w_s0 = {1'b0, ula_A} + {1'b0, ula_B};
    always_comb begin
        ula_carry_out = w_s[4];
        ula_propagado = &(ula_A ^ ula_B);
        ula_gerado    = w_s0[4];
        case (ula_seletor)
            3'b000:  ula_resultado = ula_A & ula_B;
            3'b001:  ula_resultado = ula_A | ula_B;
            3'b010:  ula_resultado = ula_A ^ ula_B;
            3'b011:  ula_resultado = ~ula_A;
            3'b100:  ula_resultado = w_s[3:0];
            3'b101:  ula_resultado = ~(ula_A & ula_B);
            3'b110:  ula_resultado = ~(ula_A | ula_B);
            default: ula_resultado = ~(ula_A ^ ula_B);
        endcase
    end

    // Wide-level reference of one whole operation
    function automatic exp_t ref_op(logic [W-1:0] a, logic [W-1:0] b,
                                    logic [2:0] sel, logic c);
        exp_t         r;
        logic [W:0]   s, s0;
        s  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        s0 = {1'b0, a} + {1'b0, b};
        r  = '0;
        case (sel)
            3'b000:  r.res = a & b;
            3'b001:  r.res = a | b;
            3'b010:  r.res = a ^ b;
            3'b011:  r.res = ~a;
            3'b100:  begin
                r.res = s[W-1:0];
                r.co  = s[W];
                r.p   = &(a ^ b);
                r.g   = s0[W];
            end
            3'b101:  r.res = ~(a & b);
            3'b110:  r.res = ~(a | b);
            default: r.res = ~(a ^ b);
        endcase
        return r;
    endfunction

    // Carry entering bit 4k of the wide sum
    function automatic logic cin_esp(logic [W-1:0] a, logic [W-1:0] b, logic c, int k);
        logic [W:0] m, s;
        m = ({{W{1'b0}}, 1'b1} << (4 * k)) - 1'b1;
        s = ({1'b0, a} & m) + ({1'b0, b} & m) + {{W{1'b0}}, c};
        return s[4 * k];
    endfunction

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_total++;
        if (obs !== esp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, esp, $time);
        end
    endtask

    // Cycle model: acceptance, busy window, done pulse, scoreboard push
    always @(posedge clk) begin
        if (!rst_n) begin
            m_cnt  = 0;
            m_done = 1'b0;
            m_a    = '0;
            m_b    = '0;
            m_sel  = 3'b000;
            m_cin  = 1'b0;
            fila.delete();
        end else begin
            m_done = (m_cnt == 1);
            if (m_cnt != 0) begin
                m_cnt--;
            end else if (start) begin
                m_a   = A;
                m_b   = B;
                m_sel = seletor;
                m_cin = carry_in;
                fila.push_back(ref_op(A, B, seletor, carry_in));
                m_cnt = NIB;
            end
        end
    end

    // Per-cycle checks on the falling edge, scoreboard pop on done
    always @(negedge clk) begin : b_chk
        int   k;
        exp_t e;
        if (chk_on) begin
            k = NIB - m_cnt;
            verifica("busy", busy, 32'(m_cnt != 0));
            verifica("done", done, 32'(m_done));
            verifica("ula_seletor", ula_seletor, m_sel);
            if (m_cnt != 0) begin
                verifica("ula_A", ula_A, m_a[4*k +: 4]);
                verifica("ula_B", ula_B, m_b[4*k +: 4]);
                verifica("ula_carry_in", ula_carry_in,
                         (m_sel == 3'b100) ? 32'(cin_esp(m_a, m_b, m_cin, k)) : 32'd0);
            end else begin
                verifica("ula_A_ocioso", ula_A, 0);
                verifica("ula_B_ocioso", ula_B, 0);
                verifica("ula_cin_ocioso", ula_carry_in, 0);
            end
            if (m_done) begin
                if (fila.size() == 0) begin
                    verifica("fila_vazia_no_done", 1, 0);
                end else begin
                    e = fila.pop_front();
                    verifica("resultado", resultado, e.res);
                    verifica("carry_out", carry_out, e.co);
                    verifica("propagado", propagado, e.p);
                    verifica("gerado", gerado, e.g);
                end
            end
        end
    end

    // Drive a one-cycle start from a falling edge; returns on the first EXEC cycle
    task automatic dispara(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] sel, input logic c);
        A        = a;
        B        = b;
        seletor  = sel;
        carry_in = c;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Bounded wait until the model is idle (lands in the done cycle)
    task automatic espera_ocioso();
        int n;
        n = 0;
        while (m_cnt != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (m_cnt != 0) verifica("timeout_ocioso", 1, 0);
    endtask

    task automatic roda(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] sel, input logic c);
        dispara(a, b, sel, c);
        espera_ocioso();
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; seletor = 3'b000; carry_in = 1'b0;
        @(posedge clk);
        chk_on = 1'b1;
        repeat (2) @(negedge clk);
        verifica("reset_resultado", resultado, 0);
        verifica("reset_flags", {carry_out, propagado, gerado}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency: start edge to done high
        dispara(16'h0005, 16'h0007, 3'b100, 1'b0);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        verifica("latencia", n, NIB);
        verifica("soma_5_7", resultado, 16'h000C);
        @(negedge clk);
        verifica("resultado_retido", resultado, 16'h000C);

        roda(16'h0005, 16'h0007, 3'b100, 1'b1);
        verifica("soma_5_7_cin", resultado, 16'h000D);

        roda(16'h8888, 16'h7777, 3'b100, 1'b1);
        verifica("8888_cin1", {resultado, carry_out, propagado, gerado}, {16'h0000, 3'b110});
        roda(16'h8888, 16'h7777, 3'b100, 1'b0);
        verifica("8888_cin0", {resultado, carry_out}, {16'hFFFF, 1'b0});

        // Carry from nibble 1 must reach nibble 2
        dispara(16'h00AA, 16'h00AA, 3'b100, 1'b0);
        @(negedge clk);
        @(negedge clk);
        verifica("cadeia_k2", ula_carry_in, 1);
        espera_ocioso();
        verifica("soma_aa", {resultado, carry_out}, {16'h0154, 1'b0});

        // Starts while busy are ignored
        dispara(16'h1111, 16'h2222, 3'b100, 1'b0);
        A = 16'hFFFF; B = 16'h0001; start = 1'b1;
        @(negedge clk);
        A = 16'h1234; seletor = 3'b000;
        @(negedge clk);
        start = 1'b0;
        espera_ocioso();
        verifica("start_ignorado", resultado, 16'h3333);

        // Start in the done cycle is accepted
        dispara(16'h1000, 16'h0FFF, 3'b100, 1'b0);
        verifica("busy_apos_done", busy, 1);
        espera_ocioso();
        verifica("soma_1000", resultado, 16'h1FFF);
        @(negedge clk);

        // Reset while k=2 aborts with no done
        dispara(16'h4321, 16'h1234, 3'b100, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        verifica("abort_busy", busy, 0);
        verifica("abort_resultado", resultado, 0);
        repeat (6) @(negedge clk);

        // Logic op: no carry chain, flags forced low
        roda(16'hF0F0, 16'hFF00, 3'b000, 1'b1);
        verifica("and_op", {resultado, carry_out, propagado, gerado}, {16'hF000, 3'b000});

        // Random mix of operations
        for (int i = 0; i < 14; i++) begin
            roda(16'($urandom), 16'($urandom),
                 ($urandom_range(0, 1) == 1) ? 3'b100 : 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        verifica("fila_final", fila.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
